demux_sched_1_4: RTL and testbench

- Controller and scheduler for the 1-to-4 demultiplexer datapath.
- Accepts a single valid/ready input stream and routes each accepted word to one of four output channels.
- Channel choice is either a round-robin rotation over enabled channels or a fixed software-selected channel.
- Contains one registered output stage that drives a shared data bus with a one-hot per-channel valid; it sits between a single producer and four consumers.

---
 rtl/demux_sched_1_4.sv | 90 +++++++++
 tb/tb_demux_sched_1_4.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_sched_1_4.sv
// Scheduler for a 1-to-4 demultiplexer: one registered output slot routed to a
// channel chosen by round-robin over enabled channels or by a fixed selection.
module demux_sched_1_4 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [1:0]    fix_sel,
    input  logic [3:0]    chan_en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [3:0]    out_valid,
    output logic [DW-1:0] out_data,
    input  logic [3:0]    out_ready,
    output logic [1:0]    cur_sel,
    output logic [1:0]    rr_ptr
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;

    logic [1:0] tgt;
    logic       tgt_ok;
    logic [1:0] idx;
    logic       rel;
    logic       accept;

    // Round-robin search walks from the highest offset down so the lowest
    // offset from ptr_q with an enabled channel wins.
    always_comb begin
        tgt    = 2'd0;
        tgt_ok = 1'b0;
        idx    = 2'd0;
        if (mode) begin
            tgt    = fix_sel;
            tgt_ok = chan_en[fix_sel];
        end else begin
            for (int i = 3; i >= 0; i--) begin
                idx = ptr_q + 2'(i);
                if (chan_en[idx]) tgt = idx;
            end
            tgt_ok = |chan_en;
        end
    end

    always_comb begin
        rel      = (state_q == FULL) && out_ready[sel_q];
        in_ready = rst_n && tgt_ok && ((state_q == EMPTY) || rel);
        accept   = in_valid && in_ready;

        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = FULL;
            data_d  = in_data;
            sel_d   = tgt;
            if (!mode) ptr_d = tgt + 2'd1;
        end else if (rel) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == FULL) ? (4'b0001 << sel_q) : 4'b0000;
    assign out_data  = data_q;
    assign cur_sel   = sel_q;
    assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_demux_sched_1_4.sv
// Scoreboard bench for demux_sched_1_4: directed words push expected channel and
// data; a monitor pops and compares whenever a channel handshake completes.
module tb_demux_sched_1_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [1:0] fix_sel;
    logic [3:0] chan_en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ready;
    logic [1:0] cur_sel;
    logic [1:0] rr_ptr;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   c0;

    demux_sched_1_4 #(.DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .fix_sel  (fix_sel),
        .chan_en  (chan_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .cur_sel  (cur_sel),
        .rr_ptr   (rr_ptr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Offer a word until accepted; the expected delivery is queued on accept.
    task automatic send(input logic [7:0] d, input logic [1:0] ch);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{ch: ch, d: d});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 32'(d), 32'hFFFF);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && ((out_valid & out_ready) != 4'b0000)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_delivery: out_valid=%b out_data=%h, required no delivery",
                         out_valid, out_data);
            end else begin
                mon_e = sb.pop_front();
                if (out_valid !== (4'b0001 << mon_e.ch) || out_data !== mon_e.d || cur_sel !== mon_e.ch) begin
                    n_bad++;
                    $display("FAIL delivery: out_valid=%b data=%h sel=%0d, required ch=%0d data=%h",
                             out_valid, out_data, cur_sel, mon_e.ch, mon_e.d);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; fix_sel = 2'd0; chan_en = 4'b1111;
        in_valid = 1'b1; in_data = 8'h11; out_ready = 4'b0000;

        // Reset holds everything idle even with a pending producer word
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_rr_ptr", rr_ptr, 2'd0);
        chk("rst_out_data", out_data, 8'h00);
        @(posedge clk); #1;
        chan_en = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_en_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("no_en_out_valid", out_valid, 4'b0000);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Round-robin rotation, back-to-back
        chan_en = 4'b1111; out_ready = 4'b1111; mode = 1'b0;
        c0 = cyc;
        send(8'hA0, 2'd0);
        send(8'hA1, 2'd1);
        send(8'hA2, 2'd2);
        send(8'hA3, 2'd3);
        chk("rr_wrap", rr_ptr, 2'd0);
        send(8'hA4, 2'd0);
        chk("rr_throughput", cyc - c0, 5);
        idle(2);
        chk("rr_ptr_after", rr_ptr, 2'd1);

        // Skip disabled channels from rr_ptr=0
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rr_ptr_reset", rr_ptr, 2'd0);
        chan_en = 4'b1010;
        send(8'hB0, 2'd1);
        send(8'hB1, 2'd3);
        send(8'hB2, 2'd1);
        idle(2);
        chk("skip_rr_ptr", rr_ptr, 2'd2);

        // Fixed mode with backpressure
        mode = 1'b1; fix_sel = 2'd2; chan_en = 4'b1111; out_ready = 4'b0000;
        send(8'h55, 2'd2);
        in_valid = 1'b1; in_data = 8'h66;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 4'b0100);
            chk("bp_out_data", out_data, 8'h55);
            @(posedge clk); #1;
        end
        out_ready = 4'b0100;
        send(8'h66, 2'd2);
        chk("bp_reload_valid", out_valid, 4'b0100);
        chk("bp_reload_data", out_data, 8'h66);
        idle(2);
        chk("fixed_rr_ptr", rr_ptr, 2'd2);

        // Configuration change while a word is held for channel 1
        mode = 1'b0; chan_en = 4'b0010; out_ready = 4'b0000;
        send(8'h77, 2'd1);
        chan_en = 4'b1101; mode = 1'b1; fix_sel = 2'd3; out_ready = 4'b1101;
        repeat (2) begin
            @(negedge clk);
            chk("cfg_out_valid", out_valid, 4'b0010);
            chk("cfg_cur_sel", cur_sel, 2'd1);
            chk("cfg_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 4'b0010;
        send(8'h88, 2'd3);
        in_valid = 1'b0;
        out_ready = 4'b1000;
        idle(2);
        chk("cfg_rr_ptr", rr_ptr, 2'd2);

        // Reset while FULL discards the held word
        out_ready = 4'b0000; fix_sel = 2'd2; chan_en = 4'b1111;
        send(8'h99, 2'd2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_full_valid", out_valid, 4'b0100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 4'b0000);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_rr_ptr", rr_ptr, 2'd0);
        out_ready = 4'b1111;
        idle(3);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
